// File: rtl/ifs_ctrl.sv
// ---------------------------------------------------------------------------
// IfsCtrl -- CAN interframe-space controller
//
// Tracks the bus between frames: bus integration after start-up or bus-off,
// the three-bit intermission, the eight-bit suspend-transmission field of an
// error-passive transmitter, and bus idle. Pulses the end of intermission,
// overload requests and start-of-frame detection.
//
// Ports
//   osc_clk          in   clock; all state changes on its rising edge
//   g_rst_n          in   asynchronous active-low reset
//   sampling_pt      in   one-cycle pulse at each nominal bit sample point
//   can_bus_in       in   sampled bus level (1 = recessive, 0 = dominant)
//   eof_done         in   pulse: last EOF bit of a frame sampled
//   ovld_err_tx_cmp  in   pulse: error/overload delimiter complete
//   node_was_tx      in   level: the ending frame was sent by this node
//   err_psv          in   level: node is error passive
//   bus_integ_req    in   pulse: request bus integration
//   rcvd_lst_bit_ifs out  pulse: last intermission bit after a received frame
//   txed_lst_bit_ifs out  pulse: last intermission bit after a sent frame
//   ovld_req         out  pulse: dominant seen in intermission bit 1 or 2
//   sof_det          out  pulse: dominant accepted as start of frame
//   bus_idle         out  level: high while in IDLE
//   ifs_state        out  current state (INTEG=0 FRAME=1 INTERM=2 SUSPEND=3 IDLE=4)
// ---------------------------------------------------------------------------
module ifs_ctrl (
    input  logic       osc_clk,
    input  logic       g_rst_n,
    input  logic       sampling_pt,
    input  logic       can_bus_in,
    input  logic       eof_done,
    input  logic       ovld_err_tx_cmp,
    input  logic       node_was_tx,
    input  logic       err_psv,
    input  logic       bus_integ_req,
    output logic       rcvd_lst_bit_ifs,
    output logic       txed_lst_bit_ifs,
    output logic       ovld_req,
    output logic       sof_det,
    output logic       bus_idle,
    output logic [2:0] ifs_state
);

    typedef enum logic [2:0] {
        ST_INTEG   = 3'd0,
        ST_FRAME   = 3'd1,
        ST_INTERM  = 3'd2,
        ST_SUSPEND = 3'd3,
        ST_IDLE    = 3'd4
    } ifs_state_e;

    // Counter values on which the final recessive bit of each field lands
    localparam logic [3:0] INTEG_LAST   = 4'd10;
    localparam logic [3:0] INTERM_LAST  = 4'd2;
    localparam logic [3:0] SUSPEND_LAST = 4'd7;

    ifs_state_e state_q, state_d;
    logic [3:0] bitCnt_q, bitCnt_d;
    logic       wasTx_q, wasTx_d;
    logic       rcvdLst_q, rcvdLst_d;
    logic       txedLst_q, txedLst_d;
    logic       ovldReq_q, ovldReq_d;
    logic       sofDet_q, sofDet_d;
    logic       busIdle_q;

    // Next-state logic. Integration requests override everything, a frame
    // end (EOF or error/overload delimiter) overrides a bit sample in the
    // same cycle, and only then is the sampled bus level looked at.
    always_comb begin
        state_d   = state_q;
        bitCnt_d  = bitCnt_q;
        wasTx_d   = wasTx_q;
        rcvdLst_d = 1'b0;
        txedLst_d = 1'b0;
        ovldReq_d = 1'b0;
        sofDet_d  = 1'b0;

        if (bus_integ_req) begin
            state_d  = ST_INTEG;
            bitCnt_d = 4'd0;
        end else if (eof_done || ovld_err_tx_cmp) begin
            // An error/overload delimiter never counts as our own transmission
            state_d  = ST_INTERM;
            bitCnt_d = 4'd0;
            wasTx_d  = eof_done ? node_was_tx : 1'b0;
        end else if (sampling_pt) begin
            case (state_q)
                ST_INTEG: begin
                    if (!can_bus_in) begin
                        bitCnt_d = 4'd0;
                    end else if (bitCnt_q == INTEG_LAST) begin
                        state_d  = ST_IDLE;
                        bitCnt_d = 4'd0;
                    end else begin
                        bitCnt_d = bitCnt_q + 4'd1;
                    end
                end
                ST_FRAME: begin
                end
                ST_INTERM: begin
                    if (!can_bus_in) begin
                        // Dominant in the third bit is a legal early SOF,
                        // earlier it signals an overload condition
                        if (bitCnt_q == INTERM_LAST) begin
                            sofDet_d = 1'b1;
                        end else begin
                            ovldReq_d = 1'b1;
                        end
                        state_d  = ST_FRAME;
                        bitCnt_d = 4'd0;
                    end else if (bitCnt_q == INTERM_LAST) begin
                        txedLst_d = wasTx_q;
                        rcvdLst_d = ~wasTx_q;
                        state_d   = (wasTx_q && err_psv) ? ST_SUSPEND : ST_IDLE;
                        bitCnt_d  = 4'd0;
                    end else begin
                        bitCnt_d = bitCnt_q + 4'd1;
                    end
                end
                ST_SUSPEND: begin
                    if (!can_bus_in) begin
                        sofDet_d = 1'b1;
                        state_d  = ST_FRAME;
                        bitCnt_d = 4'd0;
                    end else if (bitCnt_q == SUSPEND_LAST) begin
                        state_d  = ST_IDLE;
                        bitCnt_d = 4'd0;
                    end else begin
                        bitCnt_d = bitCnt_q + 4'd1;
                    end
                end
                ST_IDLE: begin
                    if (!can_bus_in) begin
                        sofDet_d = 1'b1;
                        state_d  = ST_FRAME;
                        bitCnt_d = 4'd0;
                    end
                end
                default: begin
                    // Unused encodings fall back to integration
                    state_d  = ST_INTEG;
                    bitCnt_d = 4'd0;
                end
            endcase
        end
    end

    // State and output registers; bus_idle is derived from the next state so
    // that it tracks ifs_state exactly.
    always_ff @(posedge osc_clk or negedge g_rst_n) begin
        if (!g_rst_n) begin
            state_q   <= ST_INTEG;
            bitCnt_q  <= 4'd0;
            wasTx_q   <= 1'b0;
            rcvdLst_q <= 1'b0;
            txedLst_q <= 1'b0;
            ovldReq_q <= 1'b0;
            sofDet_q  <= 1'b0;
            busIdle_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bitCnt_q  <= bitCnt_d;
            wasTx_q   <= wasTx_d;
            rcvdLst_q <= rcvdLst_d;
            txedLst_q <= txedLst_d;
            ovldReq_q <= ovldReq_d;
            sofDet_q  <= sofDet_d;
            busIdle_q <= (state_d == ST_IDLE);
        end
    end

    assign rcvd_lst_bit_ifs = rcvdLst_q;
    assign txed_lst_bit_ifs = txedLst_q;
    assign ovld_req         = ovldReq_q;
    assign sof_det          = sofDet_q;
    assign bus_idle         = busIdle_q;
    assign ifs_state        = state_q;

endmodule

// File: doc/ifs_ctrl.md
IFS_CTRL -- requirements
Module: ifs_ctrl

Interface
REQ-001 SHALL have port: osc_clk  input  1  single clock; all state changes on its rising edge.
REQ-002 SHALL have port: g_rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: sampling_pt  input  1  one-clock pulse at each nominal bit sample point.
REQ-004 SHALL have port: can_bus_in  input  1  sampled bus level; 1 = recessive, 0 = dominant; valid when sampling_pt=1.
REQ-005 SHALL have port: eof_done  input  1  one-clock pulse when the last EOF bit of a frame has been sampled.
REQ-006 SHALL have port: ovld_err_tx_cmp  input  1  one-clock pulse when an error or overload delimiter completes.
REQ-007 SHALL have port: node_was_tx  input  1  level; the frame currently ending was transmitted by this node.
REQ-008 SHALL have port: err_psv  input  1  level; the node is error passive.
REQ-009 SHALL have port: bus_integ_req  input  1  one-clock pulse requesting bus integration (start-up or bus-off recovery).
REQ-010 SHALL have port: rcvd_lst_bit_ifs  output  1  one-clock pulse; last intermission bit sampled after a received frame.
REQ-011 SHALL have port: txed_lst_bit_ifs  output  1  one-clock pulse; last intermission bit sampled after a transmitted frame.
REQ-012 SHALL have port: ovld_req  output  1  one-clock pulse; dominant level sampled in intermission bit 1 or 2.
REQ-013 SHALL have port: sof_det  output  1  one-clock pulse; dominant level accepted as start of frame.
REQ-014 SHALL have port: bus_idle  output  1  level; 1 while in IDLE.
REQ-015 SHALL have port: ifs_state  output  3  current state encoding: INTEG=0, FRAME=1, INTERM=2, SUSPEND=3, IDLE=4.

Function
REQ-016 SHALL implement a five-state FSM (INTEG, FRAME, INTERM, SUSPEND, IDLE) with a 4-bit bit counter, bit_cnt, and a 1-bit latch, was_tx.
REQ-017 SHALL register all outputs; a pulse caused by an event in clock cycle N SHALL be high only in cycle N+1.
REQ-018 SHALL give events in one cycle this priority: bus_integ_req, then eof_done or ovld_err_tx_cmp, then sampling_pt.
REQ-019 SHALL, on bus_integ_req in any state, enter INTEG with bit_cnt=0 and produce no pulse.
REQ-020 INTEG: on each sample, recessive SHALL increment bit_cnt and dominant SHALL clear it; the 11th consecutive recessive sample SHALL move the FSM to IDLE.
REQ-021 FRAME: on eof_done or ovld_err_tx_cmp, the block SHALL enter INTERM with bit_cnt=0; was_tx SHALL capture node_was_tx on eof_done and 0 on ovld_err_tx_cmp.
REQ-022 FRAME SHALL ignore samples.
REQ-023 INTERM, recessive sample: bit_cnt SHALL increment; on the third bit (bit_cnt=2) the block SHALL pulse txed_lst_bit_ifs if was_tx=1, else rcvd_lst_bit_ifs.
REQ-024 INTERM, third recessive bit: the FSM SHALL then enter SUSPEND (bit_cnt=0) if was_tx=1 and err_psv=1, else IDLE.
REQ-025 INTERM, dominant sample at bit_cnt 0 or 1: the block SHALL pulse ovld_req and enter FRAME; no last-bit pulse SHALL occur.
REQ-026 INTERM, dominant sample at bit_cnt 2: the block SHALL pulse sof_det and enter FRAME; no last-bit pulse SHALL occur.
REQ-027 SUSPEND: 8 consecutive recessive samples SHALL move the FSM to IDLE; a dominant sample SHALL pulse sof_det and enter FRAME.
REQ-028 IDLE: a dominant sample SHALL pulse sof_det and enter FRAME; recessive samples SHALL hold IDLE.
REQ-029 bus_idle SHALL equal 1 exactly while ifs_state=IDLE.
REQ-030 eof_done or ovld_err_tx_cmp outside FRAME SHALL restart INTERM with bit_cnt=0.
REQ-031 Any combination of pulse outputs SHALL be mutually exclusive within a cycle.

Reset
REQ-032 SHALL, while g_rst_n=0, force ifs_state=INTEG, bit_cnt=0, was_tx=0, all pulse outputs=0 and bus_idle=0, independent of osc_clk.
REQ-033 SHALL release from reset on the first osc_clk edge after g_rst_n rises; a reset assertion mid-intermission or mid-suspend SHALL abort it with no pulse emitted.

Verification
REQ-034 Reset release, then 11 recessive samples -> ifs_state=4 and bus_idle=1 one cycle after the 11th sample; a dominant sample at the 6th -> count restarts, 11 more required.
REQ-035 FRAME, eof_done with node_was_tx=0, then 3 recessive samples -> rcvd_lst_bit_ifs=1 for exactly one cycle after the 3rd, then ifs_state=4.
REQ-036 eof_done with node_was_tx=1 and err_psv=1, then 3 recessive samples -> txed_lst_bit_ifs pulse and ifs_state=3; 8 more recessive samples -> ifs_state=4; a dominant sample at suspend bit 5 instead -> sof_det pulse and ifs_state=1.
REQ-037 Intermission, dominant at bit 2 -> ovld_req pulse, ifs_state=1, no last-bit pulse; dominant at bit 3 -> sof_det pulse, ifs_state=1.
REQ-038 eof_done and sampling_pt(dominant) in the same cycle -> INTERM with bit_cnt=0 and no ovld_req; bus_integ_req together with eof_done -> INTEG.
REQ-039 g_rst_n low during INTERM bit 2 -> outputs immediately zero and ifs_state=0; no pulse after release.
